multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
Parametrised multi-channel edge detector for asynchronous level inputs such as buttons, sensor lines and handshake wires. Each channel has three stages:
- an input synchroniser;
- a programmable glitch filter;
- a 4-state Moore FSM producing a one-cycle tick on rising, falling or both edges, selected per channel.
Sticky pending flags let a slower controller poll events. The block sits between raw pad inputs and interrupt or control logic.

Parameters:
CH, 4, number of independent channels (1..32)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
FILT_W, 4, width of the filter length and filter counter
CNT_W, 8, event counter width (used only with EDGE_COUNT_EN)

Ports:
clk  in  1  system clock; all flops on rising edge
rst  in  1  asynchronous, active-high reset
wave  in  CH  raw asynchronous inputs, bit i = channel i
mode  in  2*CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both; quasi-static
filt_len  in  FILT_W  required extra stable cycles before a level change is accepted; shared by all channels
clr  in  CH  per-channel clear of pending (and count, if present)
tick  out  CH  one-cycle edge pulse per channel
level  out  CH  filtered, synchronised level per channel
pending  out  CH  sticky event flag per channel
any_tick  out  1  OR of all tick bits

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On reset:
  - all synchroniser flops, filter counters and pending bits = 0;
  - FSM state = LOW;
  - tick = 0, level = 0, any_tick = 0.
- Synchroniser: SYNC_STAGES flop chain per channel; its last stage is s.
- Filter counter, per channel, FILT_W bits:
  - cleared whenever s == level;
  - when s != level and counter < filt_len, increments;
  - when s != level and counter == filt_len, the change is "qualified" and the counter clears.
- FSM states and transitions, per channel. "qr" means qualified rise; "qf" means qualified fall.
  - LOW -> RISE on qr; otherwise stays LOW.
  - RISE -> FALL on qf; otherwise -> HIGH. RISE lasts exactly 1 cycle.
  - HIGH -> FALL on qf; otherwise stays HIGH.
  - FALL -> RISE on qr; otherwise -> LOW. FALL lasts exactly 1 cycle.
  - Unused encodings -> LOW.
- Outputs (Moore):
  - level = 1 in RISE or HIGH.
  - tick[i] = (state==RISE & mode[2i]) | (state==FALL & mode[2i+1]).
- Latency: wave change sampled first at edge k -> tick high for the cycle following edge k + SYNC_STAGES + filt_len.
- Glitch rejection: a synchronised excursion shorter than filt_len+1 cycles produces no state change and no tick.
- filt_len = 0: every s change is accepted. Back-to-back toggles give alternating RISE/FALL cycles, one tick each.
- filt_len change mid-count: the new value is compared immediately. If the counter already exceeds the new value, it keeps incrementing until wrap; this is accepted behaviour.
- mode = 00: tick and pending are suppressed, but the filter and level keep tracking.
- pending[i]: set on tick[i], cleared on clr[i]. If both happen in the same cycle, set wins.
- any_tick: combinational OR of tick.
- Wave high out of reset: treated as a rise, so a tick is generated after the normal latency if rise is enabled.
- Reset mid-operation: all state is lost immediately, regardless of clk.

Optional Feature:
Macro: EDGE_COUNT_EN
- Defined:
  - adds output port count, CH*CNT_W bits, channel i at [CNT_W*(i+1)-1 : CNT_W*i];
  - each channel increments on tick[i] and saturates at all-ones;
  - clr[i] clears it to 0; clr and tick in the same cycle -> count = 1;
  - reset value 0.
- Not defined: no count port and no counter logic. All other behaviour is identical.

Test Plan:
1. Reset, CH=4, filt_len=0, mode=all 11, wave[0] 0->1 at edge k -> tick[0] high exactly for cycle after edge k+2; level[0]=1 from then; pending[0]=1 until clr[0] pulses.
2. filt_len=3, mode[1]=01, wave[1] high pulse of 3 cycles -> no tick, level[1] stays 0; pulse of 6 cycles -> one tick after edge k+5, no tick on the falling edge.
3. mode[2]=10, wave[2] rises then falls after 10 cycles -> only one tick, on the fall; mode[3]=00 with toggling -> tick[3]=0, pending[3]=0, level[3] tracks.
4. filt_len=0, wave[0] toggling every cycle after sync -> state alternates RISE/FALL; mode 11 gives tick[0] high every cycle; any_tick=1 throughout.
5. clr[0] asserted in the same cycle as tick[0] -> pending[0]=1. With EDGE_COUNT_EN, count[0]=1; 300 ticks with CNT_W=8 -> count saturates at 255.
6. Assert rst asynchronously between clock edges during a count and a pending event -> all outputs 0 immediately. Hold wave=1 through reset release -> rise tick after SYNC_STAGES+filt_len edges.

Source files
------------

// File: rtl/multi_edge_detector_if.sv
// multi_edge_detector_if: pad inputs, controls and event outputs of multi_edge_detector (count exists only with EDGE_COUNT_EN)
interface multi_edge_detector_if #(
  parameter int CH = 4,
  parameter int FILT_W = 4,
  parameter int CNT_W = 8
) ();
  logic [CH-1:0] wave;
  logic [2*CH-1:0] mode;
  logic [FILT_W-1:0] filt_len;
  logic [CH-1:0] clr;
  logic [CH-1:0] tick;
  logic [CH-1:0] level;
  logic [CH-1:0] pending;
  logic any_tick;
  if (CH < 1 || CH > 32 || FILT_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("multi_edge_detector_if: parameter out of range");
  end
`ifdef EDGE_COUNT_EN
  logic [CH*CNT_W-1:0] count;
  modport master (output wave, mode, filt_len, clr, input tick, level, pending, any_tick, count);
  modport slave (input wave, mode, filt_len, clr, output tick, level, pending, any_tick, count);
`else
  modport master (output wave, mode, filt_len, clr, input tick, level, pending, any_tick);
  modport slave (input wave, mode, filt_len, clr, output tick, level, pending, any_tick);
`endif
endinterface

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: synchronised, glitch-filtered per-channel edge ticks with sticky pending; EDGE_COUNT_EN adds saturating event counters
module multi_edge_detector #(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  multi_edge_detector_if.slave bus
);
  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;
  logic [CH-1:0] tick_v;
  logic [CH-1:0] level_v;
  logic [CH-1:0] pending_v;
`ifdef EDGE_COUNT_EN
  logic [CH*CNT_W-1:0] count_v;
`endif
  if (CH < 1 || CH > 32 || SYNC_STAGES < 2 || FILT_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("multi_edge_detector: parameter out of range");
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_W-1:0] cnt;
    logic s;
    logic qual;
    logic qr;
    logic qf;
    logic pend;
    state_t state;
    state_t nxt;
    assign s = sync[SYNC_STAGES-1];
    assign qual = (s != level_v[i]) && (cnt == bus.filt_len);
    assign qr = qual && s;
    assign qf = qual && !s;
    // shift the raw pad level through the synchroniser chain
    always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else sync <= {sync[SYNC_STAGES-2:0], bus.wave[i]};
    // count cycles of disagreement with the accepted level; restart on agreement or acceptance
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (s == level_v[i] || cnt == bus.filt_len) ? '0 : cnt + 1'b1;
    // edge FSM state register
    always_ff @(posedge clk or posedge rst)
      if (rst) state <= LOW;
      else state <= nxt;
    // Moore next state; RISE and FALL each last one cycle
    always_comb begin
      nxt = LOW;
      case (state)
        LOW: nxt = qr ? RISE : LOW;
        RISE: nxt = qf ? FALL : HIGH;
        HIGH: nxt = qf ? FALL : HIGH;
        FALL: nxt = qr ? RISE : LOW;
        default: nxt = LOW;
      endcase
    end
    assign level_v[i] = (state == RISE) || (state == HIGH);
    assign tick_v[i] = (state == RISE && bus.mode[2*i]) || (state == FALL && bus.mode[2*i+1]);
    // sticky event flag; a fresh tick outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst)
      if (rst) pend <= 1'b0;
      else pend <= tick_v[i] | (pend & ~bus.clr[i]);
    assign pending_v[i] = pend;
`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] count;
    // saturating event counter; clear together with a tick leaves exactly one event
    always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else count <= bus.clr[i] ? CNT_W'(tick_v[i]) : (tick_v[i] && !(&count)) ? count + 1'b1 : count;
    assign count_v[CNT_W*i +: CNT_W] = count;
`endif
  end
  assign bus.tick = tick_v;
  assign bus.level = level_v;
  assign bus.pending = pending_v;
  assign bus.any_tick = |tick_v;
`ifdef EDGE_COUNT_EN
  assign bus.count = count_v;
`endif
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed stimulus with a tick scoreboard checked by an independent monitor
module tb_multi_edge_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    logic [3:0] v;
  } exp_t;
  exp_t q[$];
  multi_edge_detector_if #(.CH(4), .FILT_W(4), .CNT_W(8)) bus ();
  multi_edge_detector #(.CH(4), .SYNC_STAGES(2), .FILT_W(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic expect_tick(int dly, logic [3:0] v);
    q.push_back('{cyc + dly, v});
  endtask
  task automatic wait_neg(int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.tick !== 4'b0 || bus.any_tick !== 1'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got tick=%b any_tick=%b at cycle %0d, none expected", bus.tick, bus.any_tick, cyc);
      end else begin
        e = q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_vec", {28'b0, bus.tick}, {28'b0, e.v});
        chk("any_tick", {31'b0, bus.any_tick}, {31'b0, |e.v});
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.wave = 4'b0000;
    bus.mode = 8'hFF;
    bus.filt_len = 4'd0;
    bus.clr = 4'b0000;
    wait_neg(2);
    chk("reset_tick", {28'b0, bus.tick}, 0);
    chk("reset_level", {28'b0, bus.level}, 0);
    chk("reset_pending", {28'b0, bus.pending}, 0);
    chk("reset_any_tick", {31'b0, bus.any_tick}, 0);
`ifdef EDGE_COUNT_EN
    chk("reset_count", bus.count, 0);
`endif
    rst = 1'b0;
    wait_neg(2);
    bus.wave = 4'b0001;
    expect_tick(3, 4'b0001);
    wait_neg(4);
    chk("t1_level", {28'b0, bus.level}, 32'b0001);
    chk("t1_pending", {28'b0, bus.pending}, 32'b0001);
    bus.clr = 4'b0001;
    wait_neg(1);
    bus.clr = 4'b0000;
    chk("t1_pending_clr", {28'b0, bus.pending}, 0);
    bus.mode = 8'b00_10_01_11;
    bus.filt_len = 4'd3;
    bus.wave[1] = 1'b1;
    wait_neg(3);
    bus.wave[1] = 1'b0;
    wait_neg(10);
    chk("t2_glitch_level", {28'b0, bus.level}, 32'b0001);
    bus.wave[1] = 1'b1;
    expect_tick(6, 4'b0010);
    wait_neg(6);
    bus.wave[1] = 1'b0;
    wait_neg(12);
    chk("t2_level", {28'b0, bus.level}, 32'b0001);
    chk("t2_pending", {28'b0, bus.pending}, 32'b0010);
    bus.wave[2] = 1'b1;
    wait_neg(10);
    chk("t3_rise_level", {28'b0, bus.level}, 32'b0101);
    chk("t3_rise_pending", {28'b0, bus.pending}, 32'b0010);
    bus.wave[2] = 1'b0;
    expect_tick(6, 4'b0100);
    wait_neg(10);
    chk("t3_fall_level", {28'b0, bus.level}, 32'b0001);
    chk("t3_fall_pending", {28'b0, bus.pending}, 32'b0110);
    bus.wave[3] = 1'b1;
    wait_neg(8);
    chk("t3_off_level_hi", {28'b0, bus.level}, 32'b1001);
    bus.wave[3] = 1'b0;
    wait_neg(8);
    chk("t3_off_level_lo", {28'b0, bus.level}, 32'b0001);
    chk("t3_off_pending", {28'b0, bus.pending}, 32'b0110);
    bus.filt_len = 4'd0;
    bus.clr = 4'b1111;
    wait_neg(1);
    bus.clr = 4'b0000;
    chk("t4_pending_clr", {28'b0, bus.pending}, 0);
    for (int j = 0; j < 8; j++) begin
      bus.wave[0] = ~bus.wave[0];
      expect_tick(3, 4'b0001);
      wait_neg(1);
    end
    wait_neg(6);
    chk("t4_level", {28'b0, bus.level}, 32'b0001);
    bus.clr = 4'b0001;
    wait_neg(1);
    bus.clr = 4'b0000;
    bus.wave[0] = 1'b0;
    expect_tick(3, 4'b0001);
    wait_neg(3);
    bus.clr = 4'b0001;
    wait_neg(1);
    bus.clr = 4'b0000;
    chk("t5_pending_set_wins", {28'b0, bus.pending}, 32'b0001);
`ifdef EDGE_COUNT_EN
    chk("t5_count_one", {24'b0, bus.count[7:0]}, 1);
`endif
    for (int j = 0; j < 300; j++) begin
      bus.wave[0] = ~bus.wave[0];
      expect_tick(3, 4'b0001);
      wait_neg(1);
    end
    wait_neg(6);
    chk("t5_level", {28'b0, bus.level}, 0);
`ifdef EDGE_COUNT_EN
    chk("t5_count_sat", {24'b0, bus.count[7:0]}, 255);
`endif
    bus.wave[0] = 1'b1;
    expect_tick(3, 4'b0001);
    wait_neg(6);
    chk("t6_pre_level", {28'b0, bus.level}, 32'b0001);
    chk("t6_pre_pending", {28'b0, bus.pending}, 32'b0001);
    bus.filt_len = 4'd2;
    #3 rst = 1'b1;
    #1;
    chk("t6_async_tick", {28'b0, bus.tick}, 0);
    chk("t6_async_level", {28'b0, bus.level}, 0);
    chk("t6_async_pending", {28'b0, bus.pending}, 0);
    chk("t6_async_any_tick", {31'b0, bus.any_tick}, 0);
`ifdef EDGE_COUNT_EN
    chk("t6_async_count", bus.count, 0);
`endif
    wait_neg(2);
    rst = 1'b0;
    expect_tick(5, 4'b0001);
    wait_neg(8);
    chk("t6_level", {28'b0, bus.level}, 32'b0001);
    chk("t6_pending", {28'b0, bus.pending}, 32'b0001);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_ticks: got %0d outstanding expected ticks, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
